// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the branch sequencer: state encoding,
// IR field positions, and the datapath strobe bundle.
package branch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_SAMPLE = 3'd2,
        S_ADDR   = 3'd3,
        S_ADD    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int RA_MSB   = 26;
    localparam int RA_LSB   = 23;
    localparam int COND_MSB = 20;
    localparam int COND_LSB = 19;

    typedef struct packed {
        logic gra;
        logic r_out;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlo_out;
        logic pc_in;
    } strobe_t;

    function automatic logic uses_bus(input state_t s);
        return (s == S_EVAL) || (s == S_ADDR) || (s == S_ADD) || (s == S_WB);
    endfunction

endpackage

// File: rtl/branch_strobe_decode.sv
// Combinational map from sequencer state to datapath strobes; every strobe
// is gated by bus_gnt so a stalled cycle drives nothing onto the bus.
module branch_strobe_decode
    import branch_sequencer_pkg::*;
(
    input  state_t  state,
    input  logic    bus_gnt,
    input  logic    taken,
    output strobe_t strobe
);

    always_comb begin
        strobe = '0;
        if (bus_gnt) begin
            case (state)
                S_EVAL: begin
                    strobe.gra    = 1'b1;
                    strobe.r_out  = 1'b1;
                    strobe.con_in = 1'b1;
                end
                S_ADDR: begin
                    strobe.pc_out = 1'b1;
                    strobe.y_in   = 1'b1;
                end
                S_ADD: begin
                    strobe.c_out   = 1'b1;
                    strobe.alu_add = 1'b1;
                    strobe.z_in    = 1'b1;
                end
                S_WB: begin
                    strobe.zlo_out = 1'b1;
                    // Z is always written back; PC only commits when taken.
                    strobe.pc_in   = taken;
                end
                default: strobe = '0;
            endcase
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer on the shared-bus datapath.
// Optional BRANCH_SKIP_EN: not-taken branches jump SAMPLE -> DONE.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic        gra,
    output logic        r_out,
    output logic        con_in,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        z_in,
    output logic        zlo_out,
    output logic        pc_in,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        err
);

    state_t  state, next_state;
    strobe_t strobe;
    logic    is_branch;
    logic    unused_ir;

    assign is_branch = (ir[OPC_MSB:OPC_LSB] == BR_OPCODE);
    // Register and condition fields are consumed by the datapath, not here.
    assign unused_ir = ^{ir[RA_MSB:0]};

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start && is_branch) next_state = S_EVAL;
            S_EVAL:   if (bus_gnt) next_state = S_SAMPLE;
            S_SAMPLE: begin
`ifdef BRANCH_SKIP_EN
                next_state = con ? S_ADDR : S_DONE;
`else
                next_state = S_ADDR;
`endif
            end
            S_ADDR:   if (bus_gnt) next_state = S_ADD;
            S_ADD:    if (bus_gnt) next_state = S_WB;
            S_WB:     if (bus_gnt) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            taken <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (next_state == S_DONE);
            err   <= (state == S_IDLE) && start && !is_branch;
            if (state == S_SAMPLE)
                taken <= con;
            else if (state == S_IDLE && start)
                taken <= 1'b0;
        end
    end

    branch_strobe_decode u_decode (
        .state   (state),
        .bus_gnt (bus_gnt),
        .taken   (taken),
        .strobe  (strobe)
    );

    assign bus_req = uses_bus(state);
    assign gra     = strobe.gra;
    assign r_out   = strobe.r_out;
    assign con_in  = strobe.con_in;
    assign pc_out  = strobe.pc_out;
    assign y_in    = strobe.y_in;
    assign c_out   = strobe.c_out;
    assign alu_add = strobe.alu_add;
    assign z_in    = strobe.z_in;
    assign zlo_out = strobe.zlo_out;
    assign pc_in   = strobe.pc_in;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle controller that executes conditional-branch instructions on the shared-bus datapath. After instruction fetch, the main control unit hands off a decoded branch. The block then sequences the condition evaluation through the condition flip-flop, computes the target as PC + C-sign-extended offset through Y/ALU/Z, and conditionally loads PC. It arbitrates for the internal bus with a request/grant handshake and reports completion and the branch outcome.

## Interface
Parameters:
- BR_OPCODE, 5'b10010: IR[31:27] value accepted as a branch.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle pulse from the main control unit: IR holds a fetched instruction.
- ir  in  32  instruction register contents, stable from start until done.
- con  in  1  condition flip-flop output (1 = condition true).
- bus_gnt  in  1  bus granted to this block this cycle.
- bus_req  out  1  bus requested.
- gra, r_out, con_in  out  1  each  register-select and condition-latch strobes.
- pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in  out  1  each  datapath strobes.
- busy  out  1  sequence in progress.
- done  out  1  single-cycle completion pulse.
- taken  out  1  outputs the latched branch outcome; valid while done=1 and held until the next start.
- err  out  1  single-cycle pulse when start arrives with a non-branch opcode.

## Operation
- States: IDLE, EVAL, SAMPLE, ADDR, ADD, WB, DONE.
- IDLE: start=1 and ir[31:27]==BR_OPCODE → EVAL. start=1 with any other opcode → err=1 next cycle, state stays IDLE.
- EVAL: bus_req=1. When bus_gnt=1: gra=r_out=con_in=1, then → SAMPLE.
- SAMPLE: no bus use. Latch taken<=con.
  - Taken → ADDR.
  - Not taken → see Configuration.
- ADDR: bus_req=1. When bus_gnt=1: pc_out=y_in=1, then → ADD.
- ADD: bus_req=1. When bus_gnt=1: c_out=alu_add=z_in=1, then → WB.
- WB: bus_req=1. When bus_gnt=1: zlo_out=1 and pc_in=taken, then → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Bus-using states with bus_gnt=0 hold state, keep bus_req=1, and drive all strobes 0 (stall). There is no timeout.
- Strobes are combinational: decode of the current state ANDed with bus_gnt. busy, done, err and taken are registered.
- bus_req=0 in IDLE, SAMPLE and DONE.
- start while busy=1 is ignored and does not raise err.
- Reset (clear=0, at any time including mid-sequence): state IDLE and every output 0, including taken. No PC write occurs after reset assertion.

## Timing
- busy=1 in every state except IDLE.
- Full path with bus_gnt tied 1, start sampled at edge 0: EVAL in cycle 1, SAMPLE 2, ADDR 3, ADD 4, WB 5, DONE 6 (done=1), IDLE 7. Latency is 6 cycles.
- Each cycle with bus_gnt=0 in a bus-using state adds exactly 1 cycle.
- con must be valid by the end of the SAMPLE cycle, i.e. one cycle after con_in.
- A new start is accepted in the cycle after DONE, i.e. in IDLE.

## Configuration
- BRANCH_SKIP_EN defined: a not-taken branch goes SAMPLE → DONE. Latency is 3 cycles, and ADDR/ADD/WB strobes and bus_req are never asserted for it.
- BRANCH_SKIP_EN undefined: a not-taken branch still traverses ADDR/ADD/WB with pc_in=0. Latency is a fixed 6 cycles, and Z is updated while PC is unchanged.

## Structure
- Shared package:
  - state enum (3-bit encoding, IDLE=0);
  - BR_OPCODE default constant;
  - IR field positions: opcode [31:27], Ra [26:23], condition [20:19].
- Sub-module branch_strobe_decode: pure combinational map (state, bus_gnt, taken) → strobe vector. It is instantiated once.
- The FSM, registered flags and handshake stay in the top.

## Test plan
- Taken branch, con=1, bus_gnt=1, ir=0x9080_0010: strobes follow the EVAL/ADDR/ADD/WB pattern in cycles 1–5, pc_in=1 in cycle 5, done=1 and taken=1 in cycle 6.
- Not-taken branch, con=0:
  - with BRANCH_SKIP_EN, done=1 in cycle 3 and no pc_out/pc_in ever;
  - without it, done=1 in cycle 6 and pc_in=0 throughout.
- bus_gnt low for 2 cycles during ADD: state holds, all strobes 0, bus_req=1; done moves to cycle 8.
- start with ir[31:27]=5'b00011: err=1 next cycle, busy stays 0, no strobes.
- clear pulsed low during ADD: all outputs 0 immediately and the state returns to IDLE; a following start completes normally.
- start re-pulsed during WB: ignored, a single done pulse, no err.
